// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the Common Data Bus. The three ALU reservation
// stations (requesters 0-2) and the load buffer (requester 3) compete for the
// single result broadcast. At most one requester is granted per cycle, and
// the winner's tag and data are registered onto the CDB for exactly one
// cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-requester "result ready"
//   req_tag    packed ROB tags, requester i at [i*tag_width +: tag_width]
//   req_data   packed results, requester i at [i*data_width +: data_width]
//   flush      pipeline flush (branch mispredict); kills the next broadcast
//   grant      one-hot grant, combinational, same cycle as selection
//   cdb_valid  registered broadcast valid
//   cdb_tag    registered broadcast tag
//   cdb_data   registered broadcast data
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int data_width = 16,
    parameter int tag_width  = 3,
    parameter int num_req    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_req-1:0]            req,
    input  logic [num_req*tag_width-1:0]  req_tag,
    input  logic [num_req*data_width-1:0] req_data,
    input  logic                          flush,
    output logic [num_req-1:0]            grant,
    output logic                          cdb_valid,
    output logic [tag_width-1:0]          cdb_tag,
    output logic [data_width-1:0]         cdb_data
);

    // A single requester still needs a one-bit pointer to keep widths legal.
    localparam int ptr_width = (num_req > 1) ? $clog2(num_req) : 1;
    localparam logic [ptr_width-1:0] last_idx = ptr_width'(num_req - 1);

    logic [ptr_width-1:0] ptr;       // highest-priority requester this cycle
    logic [ptr_width-1:0] winner;    // index selected by the scan
    logic [ptr_width-1:0] cand;      // scan candidate
    logic                 found;
    logic                 grant_any;

    // Fully combinational scan starting at ptr, so an idle requester at the
    // pointer position costs no cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant  = '0;
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < num_req; k++) begin
            cand = ptr_width'((int'(ptr) + k) % num_req);
            if (!found && req[cand]) begin
                found         = 1'b1;
                winner        = cand;
                grant[cand]   = 1'b1;
            end
        end
        // Reset and flush suppress the grant so nothing is captured and the
        // requester keeps holding its result.
        if (reset || flush) begin
            grant = '0;
        end
    end

    assign grant_any = |grant;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            // One-cycle pulse per grant; no grant (including flush) drops it.
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_tag  <= req_tag[int'(winner)*tag_width +: tag_width];
                cdb_data <= req_data[int'(winner)*data_width +: data_width];
                ptr      <= (winner == last_idx) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed testbench for cdb_arbiter. Inputs change just after the falling
// edge; grant is sampled 1 ns later (before the next rising edge), and the
// registered CDB is sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int data_width = 16;
    localparam int tag_width  = 3;
    localparam int num_req    = 4;

    logic                          clk;
    logic                          reset;
    logic [num_req-1:0]            req;
    logic [num_req*tag_width-1:0]  req_tag;
    logic [num_req*data_width-1:0] req_data;
    logic                          flush;
    logic [num_req-1:0]            grant;
    logic                          cdb_valid;
    logic [tag_width-1:0]          cdb_tag;
    logic [data_width-1:0]         cdb_data;

    int checks;
    int errors;

    cdb_arbiter #(
        .data_width (data_width),
        .tag_width  (tag_width),
        .num_req    (num_req)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .flush     (flush),
        .grant     (grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_src(input int i, input logic [tag_width-1:0] t,
                           input logic [data_width-1:0] d);
        req_tag[i*tag_width +: tag_width]    = t;
        req_data[i*data_width +: data_width] = d;
    endtask

    // Returns the DUT to ptr=0 with idle CDB; leaves the bench just after a
    // falling edge with reset low.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        req   = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < num_req; i++) set_src(i, 3'(i + 1), 16'hA000 + 16'(i));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("FAIL reset_grant cycle %0d: got %b expected 0000", c, grant);
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 3'd0 || cdb_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cdb: got v=%b t=%0d d=%h expected v=0 t=0 d=0000",
                     cdb_valid, cdb_tag, cdb_data);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b expected 0001", grant);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 3'd1 || cdb_data !== 16'hA000) begin
            errors++;
            $display("FAIL reset_first_cdb: got v=%b t=%0d d=%h expected v=1 t=1 d=a000",
                     cdb_valid, cdb_tag, cdb_data);
        end
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        set_src(2, 3'd5, 16'h1234);
        #1;
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b expected 0100", grant);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 3'd5 || cdb_data !== 16'h1234) begin
            errors++;
            $display("FAIL single_cdb: got v=%b t=%0d d=%h expected v=1 t=5 d=1234",
                     cdb_valid, cdb_tag, cdb_data);
        end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 3'd5 || cdb_data !== 16'h1234) begin
            errors++;
            $display("FAIL single_drop: got v=%b t=%0d d=%h expected v=0 t=5 d=1234 (held)",
                     cdb_valid, cdb_tag, cdb_data);
        end
    endtask

    task automatic test_round_robin();
        logic [num_req-1:0] exp_grant [5];
        exp_grant[0] = 4'b0001;
        exp_grant[1] = 4'b0010;
        exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000;
        exp_grant[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < num_req; i++) set_src(i, 3'(i + 1), 16'hB000 + 16'(i));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (grant !== exp_grant[i]) begin
                errors++;
                $display("FAIL rr_grant step %0d: got %b expected %b", i, grant, exp_grant[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 3'((i % num_req) + 1)) begin
                errors++;
                $display("FAIL rr_cdb step %0d: got v=%b t=%0d expected v=1 t=%0d",
                         i, cdb_valid, cdb_tag, (i % num_req) + 1);
            end
            @(negedge clk);
        end
        req = '0;
    endtask

    task automatic test_skip_wrap();
        do_reset();
        // Grant requester 2 alone so ptr becomes 3.
        req = 4'b0100;
        set_src(2, 3'd3, 16'h0003);
        @(negedge clk);
        req = 4'b0011;
        set_src(0, 3'd6, 16'h6666);
        set_src(1, 3'd7, 16'h7777);
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL skip_wrap_grant: got %b expected 0001", grant);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 3'd6 || cdb_data !== 16'h6666) begin
            errors++;
            $display("FAIL skip_wrap_cdb: got v=%b t=%0d d=%h expected v=1 t=6 d=6666",
                     cdb_valid, cdb_tag, cdb_data);
        end
        // Both still requesting: ptr=1 must now favour requester 1.
        @(negedge clk); #1;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL skip_wrap_next: got %b expected 0010", grant);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_tag !== 3'd7 || cdb_data !== 16'h7777) begin
            errors++;
            $display("FAIL skip_wrap_next_cdb: got t=%0d d=%h expected t=7 d=7777",
                     cdb_tag, cdb_data);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_flush();
        do_reset();
        req = 4'b0010;
        set_src(1, 3'd6, 16'h0606);
        @(negedge clk);
        // ptr is now 2; flush while 0 and 1 request.
        req   = 4'b0011;
        flush = 1'b1;
        set_src(0, 3'd1, 16'h0101);
        #1;
        checks++;
        if (grant !== 4'b0000 || cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: got grant=%b v=%b expected grant=0000 v=1",
                     grant, cdb_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 3'd6) begin
            errors++;
            $display("FAIL flush_cdb: got v=%b t=%0d expected v=0 t=6", cdb_valid, cdb_tag);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        // ptr still 2: scan 2,3,0 selects requester 0.
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL flush_ptr_kept: got %b expected 0001", grant);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_reset_priority();
        do_reset();
        req = 4'b1000;
        set_src(3, 3'd4, 16'h4444);
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 3'd4) begin
            errors++;
            $display("FAIL rstpri_setup: got v=%b t=%0d expected v=1 t=4", cdb_valid, cdb_tag);
        end
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL rstpri_grant: got %b expected 0000", grant);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 3'd0 || cdb_data !== 16'h0000) begin
            errors++;
            $display("FAIL rstpri_cdb: got v=%b t=%0d d=%h expected v=0 t=0 d=0000",
                     cdb_valid, cdb_tag, cdb_data);
        end
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        req   = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b1000;
        set_src(3, 3'd7, 16'hBEEF);
        #1;
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_grant0: got %b expected 1000", grant);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 3'd7 || cdb_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL b2b_cdb0: got v=%b t=%0d d=%h expected v=1 t=7 d=beef",
                     cdb_valid, cdb_tag, cdb_data);
        end
        @(negedge clk);
        set_src(3, 3'd2, 16'hCAFE);
        #1;
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_grant1: got %b expected 1000", grant);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 3'd2 || cdb_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL b2b_cdb1: got v=%b t=%0d d=%h expected v=1 t=2 d=cafe",
                     cdb_valid, cdb_tag, cdb_data);
        end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got v=%b expected v=0", cdb_valid);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        req      = '0;
        req_tag  = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_flush();
        test_reset_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
